// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared control encodings for the multicycle MIPS controller.
// Opcode/funct constants, ALUOp codes, datapath select encodings and FSM states.
package mc_ctrl_pkg;
  typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT} state_e;
  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADD  = 5'd1;
  localparam logic [4:0] ALUOp_ADDU = 5'd2;
  localparam logic [4:0] ALUOp_SUB  = 5'd3;
  localparam logic [4:0] ALUOp_SUBU = 5'd4;
  localparam logic [4:0] ALUOp_AND  = 5'd5;
  localparam logic [4:0] ALUOp_OR   = 5'd6;
  localparam logic [4:0] ALUOp_XOR  = 5'd7;
  localparam logic [4:0] ALUOp_NOR  = 5'd8;
  localparam logic [4:0] ALUOp_SLT  = 5'd9;
  localparam logic [4:0] ALUOp_SLTU = 5'd10;
  localparam logic [4:0] ALUOp_SLL  = 5'd11;
  localparam logic [4:0] ALUOp_SRL  = 5'd12;
  localparam logic [4:0] ALUOp_SRA  = 5'd13;
  localparam logic [4:0] ALUOp_EQL  = 5'd14;
  localparam logic [4:0] ALUOp_BNE  = 5'd15;
  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_J = 2'd2, NPC_JR = 2'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MDR = 2'd1, WD_PC = 2'd2;
  localparam logic [1:0] GPR_RD = 2'd0, GPR_RT = 2'd1, GPR_RA = 2'd2;
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  function automatic logic is_branch(input logic [5:0] op);
    return op == OP_BEQ || op == OP_BNE;
  endfunction
endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational (opcode, funct) decode into ALU operation, shamt select,
// immediate extension mode and an instruction-legal flag.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [4:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic [1:0] ext_op_o,
  output logic       legal_o
);
  always_comb begin
    alu_op_o    = ALUOp_NOP;
    alu_src_a_o = 1'b0;
    ext_op_o    = EXT_ZERO;
    legal_o     = 1'b1;
    case (op_i)
      OP_R: case (funct_i)
        FN_SLL:  begin alu_op_o = ALUOp_SLL; alu_src_a_o = 1'b1; end
        FN_SRL:  begin alu_op_o = ALUOp_SRL; alu_src_a_o = 1'b1; end
        FN_SRA:  begin alu_op_o = ALUOp_SRA; alu_src_a_o = 1'b1; end
        FN_SLLV: alu_op_o = ALUOp_SLL;
        FN_SRLV: alu_op_o = ALUOp_SRL;
        FN_SRAV: alu_op_o = ALUOp_SRA;
        FN_JR:   legal_o  = 1'b1;
        FN_ADD:  alu_op_o = ALUOp_ADD;
        FN_ADDU: alu_op_o = ALUOp_ADDU;
        FN_SUB:  alu_op_o = ALUOp_SUB;
        FN_SUBU: alu_op_o = ALUOp_SUBU;
        FN_AND:  alu_op_o = ALUOp_AND;
        FN_OR:   alu_op_o = ALUOp_OR;
        FN_XOR:  alu_op_o = ALUOp_XOR;
        FN_NOR:  alu_op_o = ALUOp_NOR;
        FN_SLT:  alu_op_o = ALUOp_SLT;
        FN_SLTU: alu_op_o = ALUOp_SLTU;
        default: legal_o  = 1'b0;
      endcase
      OP_J, OP_JAL: legal_o = 1'b1;
      OP_BEQ:   alu_op_o = ALUOp_EQL;
      OP_BNE:   alu_op_o = ALUOp_BNE;
      OP_ADDI:  begin alu_op_o = ALUOp_ADD;  ext_op_o = EXT_SIGN; end
      OP_ADDIU: begin alu_op_o = ALUOp_ADDU; ext_op_o = EXT_SIGN; end
      OP_SLTI:  begin alu_op_o = ALUOp_SLT;  ext_op_o = EXT_SIGN; end
      OP_SLTIU: begin alu_op_o = ALUOp_SLTU; ext_op_o = EXT_SIGN; end
      OP_ANDI:  alu_op_o = ALUOp_AND;
      OP_ORI:   alu_op_o = ALUOp_OR;
      OP_XORI:  alu_op_o = ALUOp_XOR;
      OP_LUI:   ext_op_o = EXT_LUI;
      OP_LW, OP_SW: begin alu_op_o = ALUOp_ADD; ext_op_o = EXT_SIGN; end
      default:  legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM (IF/ID/EXE/MEM/WB) driving datapath selects and strobes.
// MC_ILLEGAL_TRAP_EN adds an Illegal output and a sticky S_HALT state for undefined instructions.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [4:0] ALUOp,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [1:0] EXTOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       Illegal
`endif
);
`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_e S_ILL = S_HALT;
`else
  localparam state_e S_ILL = S_IF;
`endif
  state_e     state_q, state_d;
  logic [4:0] dec_alu_op;
  logic       dec_src_a, legal;
  logic [1:0] dec_ext;
  logic       is_r, is_jr, is_ld, is_st, is_br;
  mc_alu_dec u_dec (
    .op_i(Op), .funct_i(Funct), .alu_op_o(dec_alu_op),
    .alu_src_a_o(dec_src_a), .ext_op_o(dec_ext), .legal_o(legal)
  );
  assign is_r  = Op == OP_R;
  assign is_jr = is_r && Funct == FN_JR;
  assign is_ld = Op == OP_LW;
  assign is_st = Op == OP_SW;
  assign is_br = is_branch(Op);
`ifdef MC_ILLEGAL_TRAP_EN
  assign Illegal = rst && state_q == S_HALT;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= S_IF;
    else      state_q <= state_d;
  // Outputs are all-zero while reset is held, even though the state already reads S_IF.
  always_comb begin
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    ALUOp   = ALUOp_NOP;
    ALUSrcA = 1'b0;
    ALUSrcB = 1'b0;
    EXTOp   = EXT_ZERO;
    GPRSel  = GPR_RD;
    WDSel   = WD_ALU;
    NPCOp   = NPC_PC4;
    state_d = state_q;
    if (rst) case (state_q)
      S_IF: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        state_d = S_EXE;
        if (!legal) state_d = S_ILL;
        else if (Op == OP_J || Op == OP_JAL || is_jr) begin
          PCWr    = 1'b1;
          NPCOp   = is_jr ? NPC_JR : NPC_J;
          state_d = S_IF;
          if (Op == OP_JAL) begin
            RFWr   = 1'b1;
            GPRSel = GPR_RA;
            WDSel  = WD_PC;
          end
        end
      end
      S_EXE: begin
        ALUOp   = dec_alu_op;
        ALUSrcA = dec_src_a;
        EXTOp   = dec_ext;
        ALUSrcB = !is_r && !is_br;
        state_d = (is_ld || is_st) ? S_MEM : S_WB;
        if (is_br) begin
          NPCOp   = NPC_BR;
          PCWr    = (Op == OP_BEQ) ? Zero : !Zero;
          state_d = S_IF;
        end
      end
      S_MEM: begin
        DMWr    = is_st;
        state_d = is_st ? S_IF : S_WB;
      end
      S_WB: begin
        RFWr    = 1'b1;
        GPRSel  = is_r ? GPR_RD : GPR_RT;
        WDSel   = is_ld ? WD_MDR : WD_ALU;
        state_d = S_IF;
      end
      S_HALT: state_d = S_ILL;
      default: state_d = S_IF;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven per-cycle check of mc_ctrl output vectors through a scoreboard queue,
// plus hand sequences for reset mid-store and undefined opcodes (trap or NOP build).
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;
  typedef struct {
    string nm;
    logic [31:0] ir;
    logic z;
    int n;
    logic [4:0][18:0] exp;
  } vec_t;
  typedef struct {
    logic [18:0] v;
    string nm;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, Zero = 1'b0;
  logic [5:0] Op = '0, Funct = '0;
  logic PCWr, IRWr, RFWr, DMWr, ALUSrcA, ALUSrcB;
  logic [4:0] ALUOp;
  logic [1:0] EXTOp, GPRSel, WDSel, NPCOp;
  logic [18:0] obs, IFV, Z;
  int checks = 0, errors = 0;
  exp_t exp_q[$];
  vec_t tbl[$];
`ifdef MC_ILLEGAL_TRAP_EN
  logic Illegal;
`endif
  mc_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .GPRSel(GPRSel),
    .WDSel(WDSel), .NPCOp(NPCOp)
`ifdef MC_ILLEGAL_TRAP_EN
    , .Illegal(Illegal)
`endif
  );
  always #5 clk = ~clk;
  assign obs = {PCWr, IRWr, RFWr, DMWr, ALUOp, ALUSrcA, ALUSrcB, EXTOp, GPRSel, WDSel, NPCOp};
  function automatic logic [18:0] ov(int pc, int ir, int rf, int dm, int op, int sa, int sb,
                                     int ext, int gpr, int wd, int npc);
    return {pc[0], ir[0], rf[0], dm[0], op[4:0], sa[0], sb[0], ext[1:0], gpr[1:0], wd[1:0], npc[1:0]};
  endfunction
  function automatic vec_t mk(string nm, logic [31:0] ir, logic z, int n,
                              logic [18:0] e0, logic [18:0] e1, logic [18:0] e2,
                              logic [18:0] e3, logic [18:0] e4);
    vec_t r;
    r.nm = nm; r.ir = ir; r.z = z; r.n = n;
    r.exp = {e4, e3, e2, e1, e0};
    return r;
  endfunction
  task automatic push(input logic [18:0] v, input string nm);
    exp_t e;
    e.v = v; e.nm = nm;
    exp_q.push_back(e);
  endtask
  task automatic sample();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got=%h", obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.nm, obs, e.v);
      end
    end
  endtask
  task automatic run_rec(input vec_t r);
    for (int i = 0; i < r.n; i++) push(r.exp[i], $sformatf("%s/c%0d", r.nm, i));
    for (int i = 0; i < r.n; i++) begin
      @(negedge clk);
      Op = r.ir[31:26];
      Funct = r.ir[5:0];
      Zero = (i == 2) ? r.z : 1'($urandom);
      #1 sample();
    end
  endtask
  initial begin
    IFV = ov(1, 1, 0, 0, ALUOp_NOP, 0, 0, 0, 0, 0, 0);
    Z = '0;
    tbl.push_back(mk("addu", 32'h00221821, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_ADDU,0,0,0,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,0,0,0), Z));
    tbl.push_back(mk("lw", 32'h8C220004, 0, 5, IFV, Z, ov(0,0,0,0,ALUOp_ADD,0,1,1,0,0,0), Z, ov(0,0,1,0,ALUOp_NOP,0,0,0,1,1,0)));
    tbl.push_back(mk("beq_z1", 32'h10220003, 1, 3, IFV, Z, ov(1,0,0,0,ALUOp_EQL,0,0,0,0,0,1), Z, Z));
    tbl.push_back(mk("beq_z0", 32'h10220003, 0, 3, IFV, Z, ov(0,0,0,0,ALUOp_EQL,0,0,0,0,0,1), Z, Z));
    tbl.push_back(mk("bne_z0", 32'h14220003, 0, 3, IFV, Z, ov(1,0,0,0,ALUOp_BNE,0,0,0,0,0,1), Z, Z));
    tbl.push_back(mk("bne_z1", 32'h14220003, 1, 3, IFV, Z, ov(0,0,0,0,ALUOp_BNE,0,0,0,0,0,1), Z, Z));
    tbl.push_back(mk("jal", 32'h0C000010, 0, 2, IFV, ov(1,0,1,0,ALUOp_NOP,0,0,0,2,2,2), Z, Z, Z));
    tbl.push_back(mk("j", 32'h08000010, 0, 2, IFV, ov(1,0,0,0,ALUOp_NOP,0,0,0,0,0,2), Z, Z, Z));
    tbl.push_back(mk("jr", 32'h03E00008, 0, 2, IFV, ov(1,0,0,0,ALUOp_NOP,0,0,0,0,0,3), Z, Z, Z));
    tbl.push_back(mk("sra", 32'h00021903, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_SRA,1,0,0,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,0,0,0), Z));
    tbl.push_back(mk("srav", 32'h00221907, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_SRA,0,0,0,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,0,0,0), Z));
    tbl.push_back(mk("sll", 32'h00021100, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_SLL,1,0,0,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,0,0,0), Z));
    tbl.push_back(mk("nor", 32'h00221827, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_NOR,0,0,0,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,0,0,0), Z));
    tbl.push_back(mk("sltu", 32'h0022182B, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_SLTU,0,0,0,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,0,0,0), Z));
    tbl.push_back(mk("addi", 32'h20220005, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_ADD,0,1,1,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,1,0,0), Z));
    tbl.push_back(mk("slti", 32'h28220005, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_SLT,0,1,1,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,1,0,0), Z));
    tbl.push_back(mk("ori", 32'h34210005, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_OR,0,1,0,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,1,0,0), Z));
    tbl.push_back(mk("lui", 32'h3C011234, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_NOP,0,1,2,0,0,0), ov(0,0,1,0,ALUOp_NOP,0,0,0,1,0,0), Z));
    tbl.push_back(mk("sw", 32'hAC220008, 0, 4, IFV, Z, ov(0,0,0,0,ALUOp_ADD,0,1,1,0,0,0), ov(0,0,0,1,ALUOp_NOP,0,0,0,0,0,0), Z));
    Op = OP_LW;
    repeat (2) @(posedge clk);
    #1 push(Z, "reset_hold");
    sample();
    rst = 1'b1;
    foreach (tbl[k]) run_rec(tbl[k]);
    // Store interrupted by reset in S_MEM: the write strobe must drop combinationally.
    push(IFV, "rsw/if"); push(Z, "rsw/id");
    push(ov(0,0,0,0,ALUOp_ADD,0,1,1,0,0,0), "rsw/exe");
    push(ov(0,0,0,1,ALUOp_NOP,0,0,0,0,0,0), "rsw/mem");
    push(Z, "rsw/rst_low");
    Op = OP_SW; Funct = 6'h08;
    repeat (4) begin
      @(negedge clk);
      #1 sample();
    end
    rst = 1'b0;
    #1 sample();
    @(posedge clk);
    #1 rst = 1'b1;
    run_rec(mk("after_rst_j", 32'h08000010, 0, 2, IFV, ov(1,0,0,0,ALUOp_NOP,0,0,0,0,0,2), Z, Z, Z));
`ifdef MC_ILLEGAL_TRAP_EN
    run_rec(mk("ill_op", 32'hFC000000, 0, 2, IFV, Z, Z, Z, Z));
    for (int i = 0; i < 4; i++) begin
      push(Z, $sformatf("halt/c%0d", i));
      @(negedge clk);
      Zero = 1'($urandom);
      #1 sample();
      checks++;
      if (Illegal !== 1'b1) begin
        errors++;
        $display("FAIL halt_illegal got=%b exp=1", Illegal);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    checks++;
    if (Illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after_rst got=%b exp=0", Illegal);
    end
`else
    run_rec(mk("ill_op", 32'hFC000000, 0, 2, IFV, Z, Z, Z, Z));
    run_rec(mk("ill_funct", 32'h00000001, 0, 2, IFV, Z, Z, Z, Z));
`endif
    run_rec(mk("final_if", 32'h00221821, 0, 1, IFV, Z, Z, Z, Z));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
